// File: rtl/logic_reduce_pkg.sv
// Shared definitions for the logic_reduce family: function-select codes and
// the common reduction helper used by single- and multi-channel variants.
package logic_reduce_pkg;

    localparam logic [2:0] FN_AND  = 3'b000;
    localparam logic [2:0] FN_NAND = 3'b001;
    localparam logic [2:0] FN_OR   = 3'b010;
    localparam logic [2:0] FN_NOR  = 3'b011;
    localparam logic [2:0] FN_XOR  = 3'b100;
    localparam logic [2:0] FN_XNOR = 3'b101;

    // Codes 110 and 111 are reserved; they are exactly the codes with both
    // of these bits set.
    localparam logic [2:0] FN_RSVD_MASK = 3'b110;

    // Widest input vector any variant supports.
    localparam int MAX_WIDTH = 32;

    // Reduce the low `width` bits of x as selected by func. Bits above `width`
    // are masked so that zero-extension of narrow vectors is harmless.
    function automatic logic reduce_fn(input logic [MAX_WIDTH-1:0] x,
                                       input int                   width,
                                       input logic [2:0]           func);
        logic [MAX_WIDTH-1:0] used;
        logic                 and_r;
        logic                 or_r;
        logic                 xor_r;
        logic                 r;
        used = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i < width) used[i] = 1'b1;
        end
        and_r = &(x | ~used);
        or_r  = |(x & used);
        xor_r = ^(x & used);
        r     = 1'b0;
        if ((func & FN_RSVD_MASK) != FN_RSVD_MASK) begin
            case (func)
                FN_AND:  r = and_r;
                FN_NAND: r = ~and_r;
                FN_OR:   r = or_r;
                FN_NOR:  r = ~or_r;
                FN_XOR:  r = xor_r;
                FN_XNOR: r = ~xor_r;
                default: r = 1'b0;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/logic_reduce_pipe_filter.sv
// Glitch filter: Q follows D only after FILTER+1 consecutive valid samples
// that disagree with Q; CHG pulses for one cycle on each change of Q.
module reduce_filter
    import logic_reduce_pkg::*;
#(
    parameter int FILTER = 0
) (
    input  logic CLK,
    input  logic CLR_N,
    input  logic CE,
    input  logic D,
    input  logic DV,
    output logic Q,
    output logic CHG
);

    localparam int            CW      = (FILTER < 2) ? 1 : $clog2(FILTER + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER);

    logic [CW-1:0] cnt_d, cnt_q;
    logic          of_d,  of_q;
    logic          chg_d, chg_q;

    // Count disagreeing valid samples; invalid or disabled cycles hold the run.
    always_comb begin
        cnt_d = cnt_q;
        of_d  = of_q;
        chg_d = 1'b0;
        if (CE && DV) begin
            if (D == of_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_MAX) begin
                of_d  = D;
                cnt_d = '0;
                chg_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Filter state registers; CHG clears every edge regardless of CE.
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            cnt_q <= '0;
            of_q  <= 1'b0;
            chg_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            of_q  <= of_d;
            chg_q <= chg_d;
        end
    end

    assign Q   = of_q;
    assign CHG = chg_q;

endmodule

// File: rtl/logic_reduce_pipe.sv
// Registered, parametrised inverted-input reduction gate: mask, reduce,
// STAGES-deep valid-tagged pipeline, then a glitch filter.
module logic_reduce_pipe
    import logic_reduce_pkg::*;
#(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] INV_MASK = {WIDTH{1'b1}},
    parameter int               STAGES   = 1,
    parameter int               FILTER   = 0
) (
    input  logic             CLK,
    input  logic             CLR_N,
    input  logic             CE,
    input  logic [WIDTH-1:0] I,
    input  logic [2:0]       FUNC,
    input  logic             IV,
    output logic             O,
    output logic             OV,
    output logic             OF,
    output logic             CHG
);

    logic [MAX_WIDTH-1:0] x_ext;
    logic                 r;

    // Apply the inversion mask and reduce; zero-extension is masked inside reduce_fn.
    always_comb begin
        x_ext = MAX_WIDTH'(I ^ INV_MASK);
        r     = reduce_fn(x_ext, WIDTH, FUNC);
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic data_d, data_q;
        logic vld_d,  vld_q;
        logic src_data, src_vld;

        if (s == 0) begin : g_head
            assign src_data = r;
            assign src_vld  = IV;
        end else begin : g_tail
            assign src_data = g_stage[s-1].data_q;
            assign src_vld  = g_stage[s-1].vld_q;
        end

        // Advance data and valid together on CE; otherwise hold both.
        always_comb begin
            // NOTE: defaults first so every path assigns every output -> no latch.
            data_d = data_q;
            vld_d  = vld_q;
            if (CE) begin
                data_d = src_data;
                vld_d  = src_vld;
            end
        end

        // Stage register; asynchronous clear discards data in flight.
        always_ff @(posedge CLK or negedge CLR_N) begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            if (!CLR_N) begin
                data_q <= 1'b0;
                vld_q  <= 1'b0;
            end else begin
                data_q <= data_d;
                vld_q  <= vld_d;
            end
        end
    end

    assign O  = g_stage[STAGES-1].data_q;
    assign OV = g_stage[STAGES-1].vld_q;

    reduce_filter #(
        .FILTER(FILTER)
    ) u_filter (
        .CLK  (CLK),
        .CLR_N(CLR_N),
        .CE   (CE),
        .D    (O),
        .DV   (OV),
        .Q    (OF),
        .CHG  (CHG)
    );

endmodule
